// File: rtl/key_code_voice_pkg.sv
// key_code_voice_pkg: shared voice state type, key scan codes and phase-increment table
// Contents: voice_state_t (IDLE/ATTACK/SUSTAIN/RELEASE), BREAK_CODE, NOTE_CODES,
//           PHASE_INC, note_of() code->note lookup, inc_of() note->increment lookup.
package key_code_voice_pkg;

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} voice_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hf0;

    // Entry i holds the scan code of note i+1 (C4..C5)
    localparam logic [7:0][7:0] NOTE_CODES = {
        8'h52, 8'h4c, 8'h4b, 8'h42, 8'h3b, 8'h33, 8'h34, 8'h2b
    };

    // Entry n is the per-sample phase step of note n at 48 kHz; entry 0 is silence
    localparam logic [8:0][15:0] PHASE_INC = {
        16'd714, 16'd674, 16'd601, 16'd535, 16'd477, 16'd450, 16'd401, 16'd357, 16'd0
    };

    function automatic logic [3:0] note_of(input logic [7:0] code);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = (code == NOTE_CODES[i]) ? 4'(i + 1) : n;
        return n;
    endfunction

    function automatic logic [15:0] inc_of(input logic [3:0] idx);
        return (idx > 4'd8) ? 16'd0 : PHASE_INC[idx];
    endfunction

endpackage

// File: rtl/key_code_voice_stabilizer.sv
// key_code_stabilizer: debounces key_code and emits a one-clock accept pulse per stable code
// Ports: clock, reset_n (async active-low), key_code[7:0] in;
//        accept (one-clock pulse), code[7:0] (code that was accepted) out.
module key_code_stabilizer
    import key_code_voice_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] key_code,
    output logic       accept,
    output logic [7:0] code
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] NEAR = CW'(STABLE_CYCLES - 1);

    logic [7:0]    last_code;
    logic [CW-1:0] cnt;
    logic          primed;

    // The first clock after reset adopts whatever code is present as already accepted,
    // so a key still held across a reset does not restart a note.
    // cnt == FULL means the current code has been accepted and is locked out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_code <= BREAK_CODE;
            cnt       <= '0;
            primed    <= 1'b0;
            accept    <= 1'b0;
            code      <= BREAK_CODE;
        end else begin
            primed <= 1'b1;
            accept <= 1'b0;
            if (!primed) begin
                last_code <= key_code;
                cnt       <= FULL;
            end else if (key_code != last_code) begin
                last_code <= key_code;
                cnt       <= CW'(1);
                accept    <= (STABLE_CYCLES == 1);
                code      <= key_code;
            end else if (cnt != FULL) begin
                cnt    <= cnt + CW'(1);
                accept <= (cnt == NEAR);
                code   <= key_code;
            end
        end
    end

endmodule

// File: rtl/key_code_voice.sv
// key_code_voice: single-voice key-driven synth with AD/R envelope and square or triangle output
// Ports: clock, reset_n (async active-low), key_code[7:0], sample_tick in;
//        note_active, note_idx[3:0], env[7:0], audio_out[15:0] (signed) out.
// Build option: define KEY_CODE_VOICE_TRIANGLE_EN for a triangle waveform instead of square.
module key_code_voice
    import key_code_voice_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ATTACK_STEP   = 8,
    parameter int RELEASE_STEP  = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [7:0]         key_code,
    input  logic               sample_tick,
    output logic               note_active,
    output logic [3:0]         note_idx,
    output logic [7:0]         env,
    output logic signed [15:0] audio_out
);
    voice_state_t       state, st_a, st_n;
    logic               accept, held;
    logic [7:0]         acc_code, env_n;
    logic [3:0]         acc_note, idx_a, idx_n;
    logic [8:0]         env_up;
    logic [15:0]        phase, phase_n;
    logic signed [15:0] audio_n;

    key_code_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
        .clock   (clock),
        .reset_n (reset_n),
        .key_code(key_code),
        .accept  (accept),
        .code    (acc_code)
    );

    assign acc_note = note_of(acc_code);
    assign held     = (state == ATTACK) || (state == SUSTAIN);
    assign env_up   = {1'b0, env} + 9'(ATTACK_STEP);

    // Key acceptance is resolved first; the sample step below then runs on the result
    always_comb begin
        st_a  = state;
        idx_a = note_idx;
        if (accept && acc_note != 4'd0 && !(held && acc_note == note_idx)) begin
            st_a  = ATTACK;
            idx_a = acc_note;
        end else if (accept && acc_code == BREAK_CODE && held) begin
            st_a = RELEASE;
        end
    end

    always_comb begin
        st_n    = st_a;
        idx_n   = idx_a;
        env_n   = env;
        phase_n = phase + ((sample_tick && st_a != IDLE) ? inc_of(idx_a) : 16'd0);
        if (sample_tick && st_a == ATTACK) begin
            env_n = env_up[8] ? 8'hff : env_up[7:0];
            st_n  = (env_n == 8'hff) ? SUSTAIN : ATTACK;
        end else if (sample_tick && st_a == RELEASE) begin
            env_n = (env > 8'(RELEASE_STEP)) ? env - 8'(RELEASE_STEP) : 8'd0;
            st_n  = (env_n == 8'd0) ? IDLE : RELEASE;
            idx_n = (env_n == 8'd0) ? 4'd0 : idx_a;
        end
    end

`ifdef KEY_CODE_VOICE_TRIANGLE_EN
    logic [7:0]         tri8;
    logic signed [8:0]  tri_s;
    logic signed [17:0] prod;
    assign tri8    = phase_n[15] ? ~phase_n[14:7] : phase_n[14:7];
    assign tri_s   = $signed({1'b0, tri8}) - 9'sd128;
    assign prod    = 18'(tri_s) * 18'($signed({1'b0, env_n}));
    assign audio_n = prod[15:0];
`else
    logic signed [15:0] sq;
    assign sq      = {1'b0, env_n, 7'd0};
    assign audio_n = phase_n[15] ? -sq : sq;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            note_idx    <= '0;
            env         <= '0;
            phase       <= '0;
            note_active <= 1'b0;
            audio_out   <= '0;
        end else begin
            state       <= st_n;
            note_idx    <= idx_n;
            env         <= env_n;
            phase       <= phase_n;
            note_active <= (st_n == ATTACK) || (st_n == SUSTAIN);
            audio_out   <= sample_tick ? audio_n : audio_out;
        end
    end

endmodule

// File: doc/key_code_voice.md
KEY_CODE_VOICE -- requirements
Module: key_code_voice

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive clocks key_code must hold before acceptance.
REQ-002 Parameter ATTACK_STEP, default 8: envelope increment per sample_tick in ATTACK.
REQ-003 Parameter RELEASE_STEP, default 2: envelope decrement per sample_tick in RELEASE.
REQ-004 clock  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 key_code  input  8  key scan code from the demo player or keyboard path; 8'hf0 = release.
REQ-007 sample_tick  input  1  one-clock pulse per audio sample (48 kHz).
REQ-008 note_active  output  1  high in ATTACK or SUSTAIN.
REQ-009 note_idx  output  4  currently sounding note, 1..8; 0 when IDLE.
REQ-010 env  output  8  current envelope amplitude.
REQ-011 audio_out  output  16  signed audio sample, updated only on sample_tick.

Function
REQ-012 Code map SHALL be 2b->1, 34->2, 33->3, 3b->4, 42->5, 4b->6, 4c->7, 52->8; f0->release; every other code ignored.
REQ-013 Stabilizer: any key_code change resets a stability counter; code accepted once, in the clock the counter reaches STABLE_CYCLES; no re-acceptance until key_code changes again.
REQ-014 FSM states IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-015 Accepted note code in any state: note_idx loaded, state -> ATTACK next clock; env NOT cleared (retrigger from current level); phase NOT cleared.
REQ-016 Accepted note equal to the held note_idx in ATTACK/SUSTAIN: no action.
REQ-017 ATTACK: on sample_tick env += ATTACK_STEP, saturating at 255; state -> SUSTAIN in the clock env reaches 255.
REQ-018 SUSTAIN: env held at 255.
REQ-019 Accepted f0 in ATTACK/SUSTAIN -> RELEASE; in IDLE/RELEASE ignored.
REQ-020 RELEASE: on sample_tick env -= RELEASE_STEP, saturating at 0; at 0 -> IDLE, note_idx cleared to 0.
REQ-021 Phase accumulator 16 bit, wraps modulo 2^16; on sample_tick phase += inc(note_idx) when state != IDLE; held in IDLE.
REQ-022 inc table (note 1..8): 357, 401, 450, 477, 535, 601, 674, 714 (C4..C5 at 48 kHz); inc(0) = 0.
REQ-023 Square wave (default): audio_out = phase[15] ? -(env<<7) : +(env<<7), range +/-32640.
REQ-024 audio_out registered; value computed from env and phase after that sample_tick's updates, visible one clock after the tick.
REQ-025 Accepted code and sample_tick in the same clock: state transition applies first, envelope step uses the new state.

Reset
REQ-026 reset_n low: state IDLE, env 0, phase 0, note_idx 0, note_active 0, audio_out 0, stability counter 0, last-code register 8'hf0.
REQ-027 Reset asserted mid-note aborts immediately; no release tail after deassertion.

Configuration
REQ-028 Macro KEY_CODE_VOICE_TRIANGLE_EN defined: audio_out = (tri8 - 128) * env as signed, tri8 = phase[15] ? ~phase[14:7] : phase[14:7]; undefined: square wave per REQ-023; all else identical.

Structure
REQ-029 Package key_code_voice_pkg holds the FSM state type, the eight note codes, BREAK_CODE 8'hf0 and the phase-increment table.
REQ-030 One sub-module, key_code_stabilizer, implements REQ-013 and emits a one-clock accept pulse plus the accepted code.

Verification
REQ-031 key_code 2b held 3 clocks then 00 -> no acceptance, state stays IDLE, audio_out 0.
REQ-032 key_code 2b held, ticks every 4 clocks -> ATTACK, note_idx 1, env reaches 255 after 32 ticks, SUSTAIN; phase advances 357 per tick.
REQ-033 From SUSTAIN, key_code f0 -> RELEASE, env 253 after first tick, IDLE and note_idx 0 after 128 ticks.
REQ-034 In RELEASE at env 100, key_code 42 -> ATTACK, note_idx 5, next tick env 108, inc 535.
REQ-035 Mid-SUSTAIN pulse reset_n low 1 clock -> all outputs 0 immediately; stays IDLE with key_code still 2b (no new change, no acceptance).
REQ-036 Square build, SUSTAIN, phase[15] = 1 -> audio_out = -32640; triangle build, phase 16'h0000 -> audio_out = -32640.
